// File: rtl/noc_phase_sequencer_pkg.sv
// noc_phase_sequencer_pkg: broadcast op codes, end-status codes and the phase ring.
package noc_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        NOP          = 2'd0,
        LOAD_STAGING = 2'd1,
        PHASE0       = 2'd2,
        PHASE1       = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        DONE_NONE  = 2'd0,
        DONE_DRAIN = 2'd1,
        DONE_LIMIT = 2'd2,
        DONE_ABORT = 2'd3
    } done_e;

    function automatic op_e next_phase(input op_e p);
        return (p == LOAD_STAGING) ? PHASE0 : (p == PHASE0) ? PHASE1 : LOAD_STAGING;
    endfunction

endpackage

// File: rtl/noc_ack_collector.sv
// noc_ack_collector: sticky per-router ack vector; all_acked_o also sees this clock's acks.
module noc_ack_collector #(
    parameter int unsigned NUM_ROUTERS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   acc_i,
    input  logic [NUM_ROUTERS-1:0] ack_i,
    output logic                   all_acked_o
);

    logic [NUM_ROUTERS-1:0] sticky_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) sticky_q <= '0;
        else if (acc_i) sticky_q <= sticky_q | ack_i;
    end

    assign all_acked_o = &(sticky_q | ack_i);

endmodule

// File: rtl/noc_phase_sequencer.sv
// noc_phase_sequencer: handshaked LoadStaging/Phase0/Phase1 sequencer with drain, limit, abort and timeout.
module noc_phase_sequencer
    import noc_phase_sequencer_pkg::*;
#(
    parameter int unsigned NUM_ROUTERS = 16,
    parameter int unsigned CYCLE_W     = 32,
    parameter int unsigned OP_W        = 2,
    parameter int unsigned QUIET       = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CYCLE_W-1:0]     max_cycles,
    input  logic [NUM_ROUTERS-1:0] router_ack,
    input  logic [NUM_ROUTERS-1:0] router_done,
    output logic [OP_W-1:0]        op,
    output logic                   op_valid,
    output logic [CYCLE_W-1:0]     in_cycle,
    output logic                   busy,
    output logic                   finished,
    output logic [1:0]             status,
    output logic                   err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned QW = $clog2(QUIET + 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    done_e              status_q, status_d;
    logic               op_valid_q, op_valid_d, finished_q, finished_d, err_q, err_d;
    logic [CYCLE_W-1:0] cyc_q, cyc_d, max_q, max_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [QW-1:0]      quiet_q, quiet_d, quiet_inc;
    logic               all_acked, done_all, timeout, drain, limit;

    noc_ack_collector #(.NUM_ROUTERS(NUM_ROUTERS)) u_ack (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == ISSUE),
        .acc_i      (state_q == WAIT),
        .ack_i      (router_ack),
        .all_acked_o(all_acked)
    );

    assign done_all  = &router_done;
    assign quiet_inc = (quiet_q == QW'(QUIET)) ? quiet_q : quiet_q + QW'(1);
    assign drain     = done_all && (quiet_inc >= QW'(QUIET));
    assign limit     = (max_q != '0) && (cyc_q + CYCLE_W'(1) == max_q);
    // Completion in the same clock the budget runs out still counts as completion.
    assign timeout   = (TIMEOUT != 0) && (state_q == WAIT) && !all_acked && (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op_valid_d = 1'b0;
        finished_d = 1'b0;
        status_d   = status_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        max_d      = max_q;
        tcnt_d     = tcnt_q;
        quiet_d    = quiet_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d    = ISSUE;
                op_d       = LOAD_STAGING;
                op_valid_d = 1'b1;
                max_d      = max_cycles;
                cyc_d      = '0;
                status_d   = DONE_NONE;
                err_d      = 1'b0;
                quiet_d    = '0;
            end
        end else if (abort || timeout) begin
            state_d    = IDLE;
            op_d       = NOP;
            finished_d = 1'b1;
            status_d   = DONE_ABORT;
            err_d      = err_q | timeout;
        end else if (state_q == ISSUE) begin
            state_d = WAIT;
            tcnt_d  = '0;
        end else if (!all_acked) begin
            tcnt_d = tcnt_q + TW'(1);
        end else if (op_q != PHASE1) begin
            state_d    = ISSUE;
            op_d       = next_phase(op_q);
            op_valid_d = 1'b1;
        end else begin
            quiet_d = done_all ? quiet_inc : '0;
            if (drain || limit) begin
                state_d    = IDLE;
                op_d       = NOP;
                finished_d = 1'b1;
                status_d   = drain ? DONE_DRAIN : DONE_LIMIT;
            end else begin
                state_d    = ISSUE;
                op_d       = LOAD_STAGING;
                op_valid_d = 1'b1;
                cyc_d      = cyc_q + CYCLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= NOP;
            op_valid_q <= 1'b0;
            finished_q <= 1'b0;
            status_q   <= DONE_NONE;
            err_q      <= 1'b0;
            cyc_q      <= '0;
            max_q      <= '0;
            tcnt_q     <= '0;
            quiet_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            finished_q <= finished_d;
            status_q   <= status_d;
            err_q      <= err_d;
            cyc_q      <= cyc_d;
            max_q      <= max_d;
            tcnt_q     <= tcnt_d;
            quiet_q    <= quiet_d;
        end
    end

    assign op          = OP_W'(op_q);
    assign op_valid    = op_valid_q;
    assign in_cycle    = cyc_q;
    assign busy        = (state_q != IDLE);
    assign finished    = finished_q;
    assign status      = status_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// tb_noc_phase_sequencer: randomized acks/done against a per-run reference of the phase ring and end rules.
module tb_noc_phase_sequencer;
    import noc_phase_sequencer_pkg::*;

    localparam int NR = 4, CW = 8, QUIET = 2, TIMEOUT = 8, NEVER = 1 << 20;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] max_cycles, in_cycle;
    logic [NR-1:0] router_ack, router_done;
    logic [1:0]    op, status;
    logic          op_valid, busy, finished, err_timeout;
    int            compared = 0, mismatched = 0, busy_clks = 0;

    noc_phase_sequencer #(
        .NUM_ROUTERS(NR), .CYCLE_W(CW), .OP_W(2), .QUIET(QUIET), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .max_cycles(max_cycles),
        .router_ack(router_ack), .router_done(router_done), .op(op), .op_valid(op_valid),
        .in_cycle(in_cycle), .busy(busy), .finished(finished), .status(status),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (busy === 1'b1) busy_clks++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, {op, op_valid, busy, finished}, 0);
        check({tag, "_cycle"}, in_cycle, 0);
        check({tag, "_status"}, {status, err_timeout}, 0);
    endtask

    // One run: ring L,0,1 per cycle; expected end from consecutive-done count, limit, abort, stall, reset.
    task automatic run(input int maxc, input int done_from, input int abort_cyc, input int stall_cyc,
                       input int rst_cyc, input bit stagger, input bit fixed);
        int c = 0, quiet = 0, last, exp_status = 0;
        int dly[NR];
        bit lvl[NR];
        bit fin = 0, stalled, aborting, resetting, timed_out = 0, was_reset = 0;
        logic [NR-1:0] nd;
        op_e exp_op;
        start = 1'b1;
        abort = 1'($urandom_range(0, 1));
        max_cycles = CW'(maxc);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        max_cycles = CW'($urandom);
        while (!fin) begin
            for (int p = 0; p < 3 && !fin; p++) begin
                exp_op = (p == 0) ? LOAD_STAGING : (p == 1) ? PHASE0 : PHASE1;
                check("issue_valid", op_valid, 1);
                check("issue_op", op, exp_op);
                check("issue_cycle", in_cycle, c);
                check("issue_flags", {busy, err_timeout, status}, 4'b1000);
                router_ack = NR'($urandom);
                stalled   = (c == stall_cyc) && (p == 0);
                aborting  = (c == abort_cyc) && (p == 1);
                resetting = (c == rst_cyc) && (p == 1);
                last = 1;
                for (int r = 0; r < NR; r++) begin
                    dly[r] = fixed ? 1 : $urandom_range(1, 7);
                    lvl[r] = 1'($urandom_range(0, 1));
                    if (stagger && c == 0 && p == 0) begin
                        dly[r] = (r == 0) ? 1 : 6;
                        lvl[r] = 1'b0;
                    end
                    if (dly[r] > last) last = dly[r];
                end
                if (stalled) begin
                    dly[2] = 0;
                    last = TIMEOUT;
                end
                if (aborting || resetting) last = 1;
                nd = NR'($urandom);
                if (&nd) nd[0] = 1'b0;
                for (int k = 1; k <= last; k++) begin
                    @(negedge clk);
                    check("wait_hold", {op_valid, finished, busy, op}, {3'b001, exp_op});
                    for (int r = 0; r < NR; r++)
                        router_ack[r] = (dly[r] != 0) && (lvl[r] ? (k >= dly[r]) : (k == dly[r]));
                    router_done = (p == 2) ? ((c >= done_from) ? '1 : nd) : NR'($urandom);
                    abort = aborting && (k == 1);
                    rst = resetting && (k == 1);
                    start = ($urandom_range(0, 3) == 0);
                    max_cycles = CW'($urandom);
                end
                @(negedge clk);
                {router_ack, abort, rst, start} = '0;
                if (resetting) begin
                    fin = 1;
                    was_reset = 1;
                end else if (stalled || aborting) begin
                    fin = 1;
                    exp_status = 3;
                    timed_out = stalled;
                end else if (p == 2) begin
                    quiet = (c >= done_from) ? quiet + 1 : 0;
                    if (quiet >= QUIET) begin
                        fin = 1;
                        exp_status = 1;
                    end else if (maxc != 0 && c + 1 == maxc) begin
                        fin = 1;
                        exp_status = 2;
                    end else c++;
                end
            end
        end
        if (was_reset) begin
            check_reset("rst_mid_run");
            return;
        end
        check("end_pulse", {finished, busy, op_valid, op}, 5'b10000);
        check("end_status", status, exp_status);
        check("end_cycle", in_cycle, c);
        check("end_err", err_timeout, timed_out);
        @(negedge clk);
        check("end_hold", {finished, busy, op, status}, {4'b0000, 2'(exp_status)});
    endtask

    initial begin
        int b0, m, d, ev;
        rst = 1'b1;
        {start, abort} = '0;
        max_cycles = '0;
        router_ack = '0;
        router_done = '0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        b0 = busy_clks;
        run(3, NEVER, -1, -1, -1, 0, 1);
        check("busy_clocks", busy_clks - b0, 18);
        run(2, NEVER, -1, -1, -1, 1, 0);
        run(0, 1, -1, -1, -1, 0, 0);
        run(3, 1, -1, -1, -1, 0, 0);
        run(0, NEVER, -1, 1, -1, 0, 0);
        run(2, NEVER, -1, -1, -1, 0, 0);
        run(0, NEVER, 1, -1, -1, 0, 0);
        run(0, NEVER, -1, -1, 1, 0, 0);
        run(2, NEVER, -1, -1, -1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            m = $urandom_range(0, 5);
            d = (m == 0) ? $urandom_range(0, 4) : ($urandom_range(0, 1) != 0) ? $urandom_range(0, 5) : NEVER;
            ev = $urandom_range(0, 7);
            run(m, d, (ev == 0) ? 0 : -1, (ev == 1) ? 0 : -1, -1, 0, 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
